gru_lstm_cell: RTL and testbench
================================

# gru_lstm_cell

Single-unit gated recurrent (GRU) cell computing one hidden-state update per input sample in signed 8-bit fixed point. Update/reset gates use piecewise-linear sigmoid and the candidate uses piecewise-linear tanh. Weights and biases are run-time ports, not constants, so a controller or test sequencer can reload them on any cycle. Fully pipelined: one update accepted per clock; the surrounding recurrence loop feeds `h_out` back to `h_in`.

## Interface
- `DATA_WIDTH`, 8: width of every data port; two's-complement.
- `FRACT_WIDTH`, 5: fractional bits (Q2.5, so 1.0 = 32).
- One clock; reset is synchronous and active-high.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous active-high reset.
- `in_valid`  in  1  sample the data inputs this cycle.
- `X`  in  DATA_WIDTH  input sample.
- `h_in`  in  DATA_WIDTH  previous hidden state.
- `Wz`, `Wr`, `Wh`  in  DATA_WIDTH each  input weights: update, reset, candidate.
- `Uz`, `Ur`, `Uh`  in  DATA_WIDTH each  recurrent weights: update, reset, candidate.
- `bz`, `br`, `bh`  in  DATA_WIDTH each  biases.
- `h_out`  out  DATA_WIDTH  new hidden state, registered.
- `out_valid`  out  1  `h_out` corresponds to an accepted sample.

## Operation
- All values are signed Q2.5. Products are full 16-bit Q4.10.
- `>>>F` is an arithmetic right shift by FRACT_WIDTH (floor toward −inf).
- `sat8` clamps to [−128, 127].
- Sums are formed at full width; no intermediate wrap.
- Stage 1:
  - `az = sat8(((Wz·X + Uz·h_in) >>>F) + bz)`
  - `ar = sat8(((Wr·X + Ur·h_in) >>>F) + br)`
  - Carry `Wh·X` (16-bit), `Uh`, `bh`, `h_in`.
- Stage 2:
  - Gates: `z = hsig(az)`, `r = hsig(ar)`.
  - `hsig(a) = clamp((a >>> 2) + 16, 0, 32)`.
  - `rh = sat8((r·h_in) >>>F)`.
  - `ah = sat8(((Wh·X + Uh·rh) >>>F) + bh)`.
- Stage 3:
  - `ht = clamp(ah, −32, 32)` (hard tanh).
  - `h_out = sat8(h_in + ((z·(ht − h_in)) >>>F))`, i.e. (1−z)·h_in + z·ht.
  - `ht − h_in` is 9-bit signed.
- `in_valid` travels with the data. `out_valid` equals `in_valid` delayed 3 cycles.
- Data registers load every cycle regardless of `in_valid`.
- `h_out` holds its previous value when the stage-3 valid bit is 0.
- No internal state beyond the pipeline. Recurrence is external.

## Timing
- Latency 3 cycles:
  - Inputs are sampled at edge N (with `in_valid` = 1).
  - `h_out`/`out_valid` update at edge N+2 and are visible after edge N+2, i.e. during cycle N+3.
  - Edges count from 0 at the sampling edge.
- Throughput: one sample per clock. Back-to-back samples emerge in order.
- Weights and biases are sampled at the same edge as `X`/`h_in`. Changing them later does not affect in-flight samples.
- Reset:
  - Values at any `rst` edge: all pipeline registers, `h_out` = 0, `out_valid` = 0.
  - Reset mid-stream discards all in-flight samples; no `out_valid` pulse for them.
  - Reset has priority over `in_valid` on the same edge; that sample is dropped.
- The first sample accepted after reset release yields `out_valid` 3 edges later.

## Test plan
- Reset: hold `rst` for 2 cycles with random inputs and `in_valid` = 1 -> `h_out` = 0 and `out_valid` = 0 throughout, and for 3 edges after release unless new samples are accepted.
- Neutral gates:
  - Stimulus: all weights and biases 0, `X` = 0, `h_in` = 0x20 (1.0).
  - Internals: z = r = 16; ht = 0.
  - Result: `h_out` = 0x10 (16), 3 cycles later.
- Full update:
  - Stimulus: `bz` = 127, `bh` = 0x10, other weights/biases 0, `h_in` = −32.
  - Internals: z = 32.
  - Result: `h_out` = 16.
- Hold: `bz` = −128, other weights/biases 0, `h_in` = 0x55 -> z = 0, `h_out` = 0x55 (85).
- Saturation:
  - Stimulus: `X` = 0x7F, `Wh` = 0x7F, `bz` = 127, others 0, `h_in` = 0.
  - Internals: ah saturates at 127; ht = 32.
  - Result: `h_out` = 32.
  - Repeat with `Wh` = 0x81: ht = −32, `h_out` = −32.
- Streaming and reset:
  - Stimulus: 20 random vectors back-to-back, then `rst` asserted mid-stream.
  - Outputs must match a bit-exact reference model in order at 3-cycle latency.
  - Samples in flight at reset never produce `out_valid`.
  - Includes negative products, checking floor shifting (e.g. −1·1 = −1 >>>5 = −1).

Source files
------------

// File: rtl/gru_lstm_cell_if.sv
// Sample/result bundle for the GRU cell: handshake, data, run-time weights and
// biases on the way in; registered hidden state and its valid flag on the way out.
interface gru_lstm_cell_if #(
  parameter int DATA_WIDTH = 8
);

  logic                         in_valid;
  logic signed [DATA_WIDTH-1:0] X;
  logic signed [DATA_WIDTH-1:0] h_in;
  logic signed [DATA_WIDTH-1:0] Wz;
  logic signed [DATA_WIDTH-1:0] Wr;
  logic signed [DATA_WIDTH-1:0] Wh;
  logic signed [DATA_WIDTH-1:0] Uz;
  logic signed [DATA_WIDTH-1:0] Ur;
  logic signed [DATA_WIDTH-1:0] Uh;
  logic signed [DATA_WIDTH-1:0] bz;
  logic signed [DATA_WIDTH-1:0] br;
  logic signed [DATA_WIDTH-1:0] bh;
  logic signed [DATA_WIDTH-1:0] h_out;
  logic                         out_valid;

  modport master (
    output in_valid, X, h_in, Wz, Wr, Wh, Uz, Ur, Uh, bz, br, bh,
    input  h_out, out_valid
  );

  modport slave (
    input  in_valid, X, h_in, Wz, Wr, Wh, Uz, Ur, Uh, bz, br, bh,
    output h_out, out_valid
  );

endinterface

// File: rtl/gru_lstm_cell.sv
// Single-unit GRU cell, signed fixed point, three register stages:
//   stage 1: update/reset pre-activations az, ar; carry Wh*X, Uh, bh, h_in
//   stage 2: gates z, r (hard sigmoid), r*h_in, candidate pre-activation ah
//   stage 3: hard tanh and blend h_in + z*(ht - h_in) into h_out
// All sums are formed at full width and only saturated where noted.
module gru_lstm_cell #(
  parameter int DATA_WIDTH  = 8,
  parameter int FRACT_WIDTH = 5
) (
  input logic            clk,
  input logic            rst,
  gru_lstm_cell_if.slave bus
);

  localparam int DW = DATA_WIDTH;
  localparam int FW = FRACT_WIDTH;
  localparam int PW = 2 * DW;          // full product width
  localparam int SW = PW + 2;          // headroom for sums of products
  localparam int GW = FW + 1;          // gate value 0 .. 1.0 inclusive

  localparam logic signed [SW-1:0] SAT_HI    = SW'((1 << (DW - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_LO    = SW'(-(1 << (DW - 1)));
  localparam logic signed [DW:0]   GATE_HALF = (DW + 1)'(1 << (FW - 1));
  localparam logic signed [DW:0]   GATE_ONE  = (DW + 1)'(1 << FW);
  localparam logic signed [DW-1:0] TANH_HI   = DW'(1 << FW);
  localparam logic signed [DW-1:0] TANH_LO   = DW'(-(1 << FW));

  // Clamp a wide signed value into the data range.
  function automatic logic signed [DW-1:0] sat(input logic signed [SW-1:0] v);
    if (v > SAT_HI) begin
      sat = SAT_HI[DW-1:0];
    end else if (v < SAT_LO) begin
      sat = SAT_LO[DW-1:0];
    end else begin
      sat = v[DW-1:0];
    end
  endfunction

  // Piecewise-linear sigmoid: slope 1/4 around 0.5, clamped to [0, 1.0].
  function automatic logic [GW-1:0] hsig(input logic signed [DW-1:0] a);
    logic signed [DW:0] t;
    t = (DW + 1)'(a >>> 2) + GATE_HALF;
    if (t < 0) begin
      hsig = '0;
    end else if (t > GATE_ONE) begin
      hsig = GATE_ONE[GW-1:0];
    end else begin
      hsig = t[GW-1:0];
    end
  endfunction

  // ---------------------------------------------------------------- stage 1
  logic signed [PW-1:0] wzx, uzh, wrx, urh, whx;
  logic signed [SW-1:0] pre_z, pre_r;
  logic signed [DW-1:0] az_d, ar_d;

  assign wzx   = PW'(bus.Wz) * PW'(bus.X);
  assign uzh   = PW'(bus.Uz) * PW'(bus.h_in);
  assign wrx   = PW'(bus.Wr) * PW'(bus.X);
  assign urh   = PW'(bus.Ur) * PW'(bus.h_in);
  assign whx   = PW'(bus.Wh) * PW'(bus.X);
  assign pre_z = ((SW'(wzx) + SW'(uzh)) >>> FW) + SW'(bus.bz);
  assign pre_r = ((SW'(wrx) + SW'(urh)) >>> FW) + SW'(bus.br);
  assign az_d  = sat(pre_z);
  assign ar_d  = sat(pre_r);

  logic signed [DW-1:0] az_q, ar_q, uh_q, bh_q, h1_q;
  logic signed [PW-1:0] whx_q;
  logic                 v1_q;

  // Stage-1 register: gate pre-activations plus everything the candidate needs.
  always_ff @(posedge clk) begin
    if (rst) begin
      az_q  <= '0;
      ar_q  <= '0;
      whx_q <= '0;
      uh_q  <= '0;
      bh_q  <= '0;
      h1_q  <= '0;
      v1_q  <= 1'b0;
    end else begin
      az_q  <= az_d;
      ar_q  <= ar_d;
      whx_q <= whx;
      uh_q  <= bus.Uh;
      bh_q  <= bus.bh;
      h1_q  <= bus.h_in;
      v1_q  <= bus.in_valid;
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [GW-1:0]        z_d, r_d;
  logic signed [PW-1:0] rh_prod, uhrh;
  logic signed [DW-1:0] rh, ah_d;
  logic signed [SW-1:0] pre_h;

  assign z_d     = hsig(az_q);
  assign r_d     = hsig(ar_q);
  assign rh_prod = PW'($signed({1'b0, r_d})) * PW'(h1_q);
  assign rh      = sat(SW'(rh_prod) >>> FW);
  assign uhrh    = PW'(uh_q) * PW'(rh);
  assign pre_h   = ((SW'(whx_q) + SW'(uhrh)) >>> FW) + SW'(bh_q);
  assign ah_d    = sat(pre_h);

  logic [GW-1:0]        z_q;
  logic signed [DW-1:0] ah_q, h2_q;
  logic                 v2_q;

  // Stage-2 register: update gate, candidate pre-activation, previous state.
  always_ff @(posedge clk) begin
    if (rst) begin
      z_q  <= '0;
      ah_q <= '0;
      h2_q <= '0;
      v2_q <= 1'b0;
    end else begin
      z_q  <= z_d;
      ah_q <= ah_d;
      h2_q <= h1_q;
      v2_q <= v1_q;
    end
  end

  // ---------------------------------------------------------------- stage 3
  logic signed [DW-1:0] ht, h_out_d;
  logic signed [DW:0]   diff;
  logic signed [SW-1:0] mix, upd_h;

  assign ht      = (ah_q > TANH_HI) ? TANH_HI : ((ah_q < TANH_LO) ? TANH_LO : ah_q);
  // ht - h_in spans one bit more than the data width.
  assign diff    = (DW + 1)'(ht) - (DW + 1)'(h2_q);
  assign mix     = SW'($signed({1'b0, z_q})) * SW'(diff);
  assign upd_h   = SW'(h2_q) + (mix >>> FW);
  assign h_out_d = sat(upd_h);

  // Output register: h_out only moves for valid samples, valid flag every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.h_out     <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= v2_q;
      if (v2_q) begin
        bus.h_out <= h_out_d;
      end
    end
  end

endmodule

// File: tb/tb_gru_lstm_cell.sv
// Bench for gru_lstm_cell: directed gate/saturation cases, reset behaviour and
// a randomized stream, all compared against an integer reference model.
module tb_gru_lstm_cell;

  localparam int DW = 8;
  localparam int FW = 5;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  gru_lstm_cell_if #(.DATA_WIDTH(DW)) bus ();

  gru_lstm_cell #(.DATA_WIDTH(DW), .FRACT_WIDTH(FW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int due;
    int val;
  } exp_t;

  exp_t sb[$];
  int   tests  = 0;
  int   fails  = 0;
  int   edge_n = 0;
  int   exp_h  = 0;
  int   exp_v  = 0;

  // ------------------------------------------------------------ reference model
  function automatic int sat8(input int v);
    return (v > 127) ? 127 : ((v < -128) ? -128 : v);
  endfunction

  function automatic int hsig(input int a);
    int t;
    t = (a >>> 2) + 16;
    return (t < 0) ? 0 : ((t > 32) ? 32 : t);
  endfunction

  function automatic int gru_ref(input int x, h, wz, wr, wh, uz, ur, uh, bz, br, bh);
    int z, r, rh, ah, ht;
    z  = hsig(sat8(((wz * x + uz * h) >>> 5) + bz));
    r  = hsig(sat8(((wr * x + ur * h) >>> 5) + br));
    rh = sat8((r * h) >>> 5);
    ah = sat8(((wh * x + uh * rh) >>> 5) + bh);
    ht = (ah > 32) ? 32 : ((ah < -32) ? -32 : ah);
    return sat8(h + ((z * (ht - h)) >>> 5));
  endfunction

  function automatic int model_now();
    return gru_ref(int'(bus.X), int'(bus.h_in), int'(bus.Wz), int'(bus.Wr), int'(bus.Wh),
                   int'(bus.Uz), int'(bus.Ur), int'(bus.Uh),
                   int'(bus.bz), int'(bus.br), int'(bus.bh));
  endfunction

  // ------------------------------------------------------------ helpers
  task automatic check(input string tag, input logic signed [15:0] obs,
                       input logic signed [15:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic set_vec(input int x, h, wz, wr, wh, uz, ur, uh, bz, br, bh, input bit vld);
    bus.X  = 8'(x);   bus.h_in = 8'(h);
    bus.Wz = 8'(wz);  bus.Wr = 8'(wr);  bus.Wh = 8'(wh);
    bus.Uz = 8'(uz);  bus.Ur = 8'(ur);  bus.Uh = 8'(uh);
    bus.bz = 8'(bz);  bus.br = 8'(br);  bus.bh = 8'(bh);
    bus.in_valid = vld;
  endtask

  function automatic int r8();
    logic [7:0] b;
    b = 8'($urandom);
    return int'($signed(b));
  endfunction

  function automatic int rsmall();
    return int'($urandom_range(0, 64)) - 32;
  endfunction

  task automatic rand_vec(input bit vld);
    if ($urandom_range(0, 1) == 0)
      set_vec(r8(), r8(), r8(), r8(), r8(), r8(), r8(), r8(), r8(), r8(), r8(), vld);
    else
      set_vec(rsmall(), rsmall(), rsmall(), rsmall(), rsmall(), rsmall(), rsmall(),
              rsmall(), rsmall(), rsmall(), rsmall(), vld);
  endtask

  // One clock: log the sample the DUT is about to accept, then check outputs
  // 1 time unit after the edge against the scoreboard.
  task automatic tick();
    exp_t e;
    if (rst) begin
      sb.delete();
    end else if (bus.in_valid) begin
      e.due = edge_n + 2;
      e.val = model_now();
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      exp_v = 0;
      exp_h = 0;
    end else if (sb.size() > 0 && sb[0].due == edge_n) begin
      e     = sb.pop_front();
      exp_v = 1;
      exp_h = e.val;
    end else begin
      exp_v = 0;
    end
    check("out_valid", 16'(bus.out_valid), 16'(exp_v));
    check("h_out", 16'(bus.h_out), 16'(exp_h));
    edge_n++;
  endtask

  // Push one sample, then two idle cycles so its result is visible.
  task automatic directed(input string tag, input int x, h, wz, wr, wh, uz, ur, uh,
                          bz, br, bh, input int want);
    set_vec(x, h, wz, wr, wh, uz, ur, uh, bz, br, bh, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    check({tag, "_valid"}, 16'(bus.out_valid), 16'sd1);
    check(tag, 16'(bus.h_out), 16'(want));
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    rst = 1'b1;
    rand_vec(1'b1);
    tick();
    rand_vec(1'b1);
    tick();
    check("rst_h_out", 16'(bus.h_out), 16'sd0);
    check("rst_valid", 16'(bus.out_valid), 16'sd0);

    rst = 1'b0;
    rand_vec(1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_valid", 16'(bus.out_valid), 16'sd0);
    end

    directed("neutral",    0,   32, 0, 0,    0, 0, 0, 0,    0, 0,  0,  16);
    directed("full_upd",   0,  -32, 0, 0,    0, 0, 0, 0,  127, 0, 16,  16);
    directed("hold",       0,   85, 0, 0,    0, 0, 0, 0, -128, 0,  0,  85);
    directed("sat_pos",  127,    0, 0, 0,  127, 0, 0, 0,  127, 0,  0,  32);
    directed("sat_neg",  127,    0, 0, 0, -127, 0, 0, 0,  127, 0,  0, -32);
    directed("floor",      1,    0, 0, 0,   -1, 0, 0, 0,  127, 0,  0,  -1);

    // Weights change right after sampling; the in-flight result must not move.
    set_vec(0, 32, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
    tick();
    set_vec(99, -70, 120, -120, 120, 120, 120, -120, 120, 120, 120, 1'b0);
    tick();
    tick();
    check("late_weights", 16'(bus.h_out), 16'sd16);

    // Back-to-back random stream, then reset while samples are in flight.
    for (int i = 0; i < 20; i++) begin
      rand_vec(1'b1);
      tick();
    end
    rst = 1'b1;
    rand_vec(1'b1);
    tick();
    rst = 1'b0;
    rand_vec(1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("flushed_valid", 16'(bus.out_valid), 16'sd0);
    end

    // Random stream with gaps.
    for (int i = 0; i < 40; i++) begin
      rand_vec(($urandom_range(0, 3) != 0));
      tick();
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("drained", 16'(sb.size()), 16'sd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
